// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage pipeline: run/idle/drain/halt FSM,
// load-use stall and branch flush. Counters exist only with PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic             branch_taken_i,
    input  logic             halt_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          lu;

    // x0 is never a real producer, so it can never cause a load-use stall
    assign lu = idex_memread_i && (idex_rd_i != 5'd0) &&
                ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b1;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                // Dropping start freezes the pipe in this very cycle
                if (!start_i || lu) begin
                end else if (branch_taken_i) begin
                    pc_write_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b0;
                end else if (halt_i) begin
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                end else begin
                    pc_write_o    = 1'b1;
                    ifid_write_o  = 1'b1;
                    idex_bubble_o = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = HALTED;
                else               drain_d = drain_q - DW'(1);
            end
            HALTED: begin
            end
            default: state_d = IDLE;
        endcase
        if (!start_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign halted_o = (state_q == HALTED);
    assign state_o  = state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (state_q == RUN && lu)                    stall_cnt_d = sat_inc(stall_cnt_q);
        if (state_q == RUN && !lu && branch_taken_i) flush_cnt_d = sat_inc(flush_cnt_q);
        if (state_q == RUN || state_q == DRAIN)      cycle_cnt_d = sat_inc(cycle_cnt_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign cycle_cnt_o = '0;
`endif

endmodule
